// File: rtl/sc_note_serializer_if.sv
// rtl/sc_note_serializer_if.sv - note word input handshake between the note source and the serializer
interface sc_note_serializer_if #(
   parameter int WIDTH = 37
) ();
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sc_note_serializer.sv
// rtl/sc_note_serializer.sv - FIFO-buffered framed serial transmitter for note words
module sc_note_serializer #(
   parameter int WIDTH        = 37,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        pause,
   sc_note_serializer_if.slave         in_if,
   output logic                        tx,
   output logic                        tx_busy,
   output logic                        frame_done,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = PW + 1;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state;
   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [NW-1:0]    count;
   logic [WIDTH-1:0] shreg;
   logic             parity;
   logic [CW-1:0]    cyc;
   logic [BW-1:0]    bit_cnt;
   logic             push;
   logic             pop;
   logic             cyc_last;
   logic             bit_last;

   // in_ready looks only at the registered count, so a full FIFO refuses a word even on a pop cycle
   assign in_if.in_ready = (count != NW'(FIFO_DEPTH));
   assign push           = in_if.in_valid && in_if.in_ready;
   assign pop            = (state == IDLE) && (count != '0) && !pause;
   assign cyc_last       = (cyc == CW'(CLKS_PER_BIT - 1));
   assign bit_last       = (bit_cnt == BW'(WIDTH - 1));
   assign fifo_count     = count;
   assign tx_busy        = (state != IDLE);
   assign frame_done     = (state == STOP) && cyc_last;

   // FIFO storage write; contents need no reset because count gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_if.in_data;
      end
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // Frame sequencer: start, WIDTH data bits LSB first, even parity, stop; each bit CLKS_PER_BIT cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         parity  <= 1'b0;
         cyc     <= '0;
         bit_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  shreg   <= mem[rd_ptr];
                  parity  <= ^mem[rd_ptr];
                  cyc     <= '0;
                  bit_cnt <= '0;
                  state   <= START;
               end
            end
            START: begin
               cyc <= cyc_last ? '0 : cyc + 1'b1;
               if (cyc_last) begin
                  state <= DATA;
               end
            end
            DATA: begin
               cyc <= cyc_last ? '0 : cyc + 1'b1;
               if (cyc_last) begin
                  shreg   <= shreg >> 1;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_last) begin
                     state <= PARITY;
                  end
               end
            end
            PARITY: begin
               cyc <= cyc_last ? '0 : cyc + 1'b1;
               if (cyc_last) begin
                  state <= STOP;
               end
            end
            STOP: begin
               cyc <= cyc_last ? '0 : cyc + 1'b1;
               if (cyc_last) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Line level decoded from registered state only, so it cannot glitch within a bit
   always_comb begin
      tx = 1'b1;
      case (state)
         START:   tx = 1'b0;
         DATA:    tx = shreg[0];
         PARITY:  tx = parity;
         default: tx = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_sc_note_serializer.sv
// tb/tb_sc_note_serializer.sv - randomized self-checking bench for sc_note_serializer
module tb_sc_note_serializer;
   localparam int W     = 37;
   localparam int CPB   = 4;
   localparam int FD    = 4;
   localparam int FRAME = (W + 3) * CPB;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         pause = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         tx;
   logic         tx_busy;
   logic         frame_done;
   logic [2:0]   fifo_count;

   int total = 0;
   int bad = 0;
   int cyc_n = 0;

   sc_note_serializer_if #(.WIDTH(W)) nif ();
   assign nif.in_data  = in_data;
   assign nif.in_valid = in_valid;

   sc_note_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .pause(pause), .in_if(nif.slave),
      .tx(tx), .tx_busy(tx_busy), .frame_done(frame_done), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // receiver-side observations, filled by the line monitor
   logic [W-1:0] rx_word[$];
   logic         rx_par[$];
   bit           rx_good[$];
   int           rx_start[$];
   int           done_q[$];
   int           busy_cnt;
   logic [W-1:0] exp_q[$];

   // line monitor: captures a whole frame after a falling start edge and decodes it
   initial begin
      logic fs [FRAME];
      int fs_n;
      int fs_start;
      bit in_frame;
      logic [W-1:0] dw;
      logic dv;
      logic dpar;
      bit dgood;
      fs_n = 0; fs_start = 0; in_frame = 0; busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            in_frame = 0;
         end else begin
            if (!in_frame && tx === 1'b0) begin
               in_frame = 1; fs_n = 0; fs_start = cyc_n;
            end
            if (in_frame) begin
               fs[fs_n] = tx;
               fs_n++;
               if (fs_n == FRAME) begin
                  dw = '0; dgood = 1; dpar = 1'bx;
                  for (int b = 0; b < W + 3; b++) begin
                     dv = fs[b*CPB];
                     for (int k = 1; k < CPB; k++) if (fs[b*CPB+k] !== dv) dgood = 0;
                     if (b == 0 && dv !== 1'b0) dgood = 0;
                     if (b >= 1 && b <= W) dw[b-1] = dv;
                     if (b == W + 1) dpar = dv;
                     if (b == W + 2 && dv !== 1'b1) dgood = 0;
                  end
                  rx_word.push_back(dw); rx_par.push_back(dpar);
                  rx_good.push_back(dgood); rx_start.push_back(fs_start);
                  in_frame = 0;
               end
            end
         end
         if (frame_done === 1'b1) done_q.push_back(cyc_n);
         if (tx_busy === 1'b1) busy_cnt++;
      end
   end

   function automatic logic [W-1:0] rand_word();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[W-1:0];
   endfunction

   // even parity as a count of ones
   function automatic logic model_par(input logic [W-1:0] d);
      return (($countones(d) % 2) == 1);
   endfunction

   function automatic void clear_obs();
      rx_word.delete(); rx_par.delete(); rx_good.delete(); rx_start.delete();
      done_q.delete(); exp_q.delete(); busy_cnt = 0;
   endfunction

   // called at a negedge; presents one word for exactly one edge
   task automatic push_now(input logic [W-1:0] d, output int acc_edge, output bit acc);
      in_valid = 1'b1; in_data = d;
      acc = (nif.in_ready === 1'b1);
      acc_edge = cyc_n + 1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget);
      int t;
      t = 0;
      while (rx_word.size() < n && t < budget) begin
         @(negedge clk); t++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (tx !== 1'b1) begin $display("FAIL reset_tx: got %b want 1", tx); bad++; end
      total++; if (tx_busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", tx_busy); bad++; end
      total++; if (frame_done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", frame_done); bad++; end
      total++; if (fifo_count !== 3'd0) begin $display("FAIL reset_count: got %0d want 0", fifo_count); bad++; end
      total++; if (nif.in_ready !== 1'b1) begin $display("FAIL reset_ready: got %b want 1", nif.in_ready); bad++; end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      int e; bit acc; logic [W-1:0] d;
      clear_obs();
      d = 37'h0_0000_0007;
      push_now(d, e, acc);
      total++; if (fifo_count !== 3'd1) begin $display("FAIL single_count: got %0d want 1", fifo_count); bad++; end
      wait_rx(1, 2 * FRAME);
      repeat (20) @(negedge clk);
      total++; if (rx_word.size() != 1) begin $display("FAIL single_frames: got %0d want 1", rx_word.size()); bad++; end
      else begin
         total++; if (rx_start[0] != e + 1) begin $display("FAIL single_latency: got %0d want %0d", rx_start[0], e + 1); bad++; end
         total++; if (rx_word[0] !== d) begin $display("FAIL single_word: got %h want %h", rx_word[0], d); bad++; end
         total++; if (rx_par[0] !== model_par(d)) begin $display("FAIL single_parity: got %b want %b", rx_par[0], model_par(d)); bad++; end
         total++; if (rx_good[0] !== 1'b1) begin $display("FAIL single_framing: got %b want 1", rx_good[0]); bad++; end
         total++; if (done_q.size() != 1 || done_q[0] != rx_start[0] + FRAME - 1) begin
            $display("FAIL single_done: got n=%0d at %0d want at %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, rx_start[0] + FRAME - 1); bad++; end
      end
      total++; if (busy_cnt != FRAME) begin $display("FAIL single_busy: got %0d want %0d", busy_cnt, FRAME); bad++; end
   endtask

   task automatic test_fill();
      int e; bit acc; bit exp_rdy; bit mpop; bit running; int mc; logic [W-1:0] d;
      clear_obs();
      mc = 0; running = 0;
      for (int k = 0; k < 5; k++) begin
         d = rand_word();
         exp_rdy = (mc < FD);
         push_now(d, e, acc);
         total++; if (acc !== exp_rdy) begin $display("FAIL fill_accept[%0d]: got %b want %b", k, acc, exp_rdy); bad++; end
         if (exp_rdy) exp_q.push_back(d);
         mpop = !running && mc > 0;
         if (mpop) running = 1;
         mc = mc + (exp_rdy ? 1 : 0) - (mpop ? 1 : 0);
      end
      total++; if (nif.in_ready !== (mc < FD)) begin $display("FAIL fill_ready: got %b want %b", nif.in_ready, mc < FD); bad++; end
      total++; if (fifo_count != mc) begin $display("FAIL fill_count: got %0d want %0d", fifo_count, mc); bad++; end
      wait_rx(exp_q.size(), exp_q.size() * (FRAME + 1) + 100);
      total++; if (rx_word.size() != exp_q.size()) begin $display("FAIL fill_frames: got %0d want %0d", rx_word.size(), exp_q.size()); bad++; end
      for (int i = 0; i < exp_q.size() && i < rx_word.size(); i++) begin
         total++; if (rx_word[i] !== exp_q[i]) begin $display("FAIL fill_word[%0d]: got %h want %h", i, rx_word[i], exp_q[i]); bad++; end
         total++; if (rx_par[i] !== model_par(exp_q[i])) begin $display("FAIL fill_parity[%0d]: got %b want %b", i, rx_par[i], model_par(exp_q[i])); bad++; end
         total++; if (rx_good[i] !== 1'b1) begin $display("FAIL fill_framing[%0d]: got %b want 1", i, rx_good[i]); bad++; end
         if (i > 0) begin
            total++; if (rx_start[i] - rx_start[i-1] != FRAME + 1) begin
               $display("FAIL fill_gap[%0d]: got %0d want %0d", i, rx_start[i] - rx_start[i-1], FRAME + 1); bad++; end
         end
      end
      for (int i = 0; i < done_q.size() && i < rx_start.size(); i++) begin
         total++; if (done_q[i] != rx_start[i] + FRAME - 1) begin $display("FAIL fill_done[%0d]: got %0d want %0d", i, done_q[i], rx_start[i] + FRAME - 1); bad++; end
      end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_full_pop();
      int e0; int e; bit acc; int s1; int t; int r; logic [W-1:0] d;
      clear_obs();
      d = rand_word(); push_now(d, e0, acc); exp_q.push_back(d);
      s1 = e0 + 1;
      for (int k = 1; k < 5; k++) begin
         d = rand_word(); push_now(d, e, acc); exp_q.push_back(d);
      end
      total++; if (fifo_count !== 3'd4) begin $display("FAIL fullpop_count: got %0d want 4", fifo_count); bad++; end
      in_valid = 1'b1; in_data = rand_word();
      t = 0;
      while (nif.in_ready !== 1'b1 && t < 2 * FRAME) begin
         @(negedge clk); t++;
      end
      in_valid = 1'b0;
      r = cyc_n;
      total++; if (r != s1 + FRAME + 1) begin $display("FAIL fullpop_ready_cycle: got %0d want %0d", r, s1 + FRAME + 1); bad++; end
      total++; if (fifo_count !== 3'd3) begin $display("FAIL fullpop_after_pop: got %0d want 3", fifo_count); bad++; end
      wait_rx(5, 5 * (FRAME + 1) + 100);
      repeat (200) @(negedge clk);
      total++; if (rx_word.size() != 5) begin $display("FAIL fullpop_frames: got %0d want 5", rx_word.size()); bad++; end
      for (int i = 0; i < 5 && i < rx_word.size(); i++) begin
         total++; if (rx_word[i] !== exp_q[i]) begin $display("FAIL fullpop_word[%0d]: got %h want %h", i, rx_word[i], exp_q[i]); bad++; end
      end
   endtask

   task automatic test_pause();
      int e; bit acc; int dcyc; bit flag; logic [W-1:0] d;
      clear_obs();
      for (int k = 0; k < 3; k++) begin
         d = rand_word(); push_now(d, e, acc); exp_q.push_back(d);
      end
      repeat (40) @(negedge clk);
      pause = 1'b1;
      wait_rx(1, 2 * FRAME);
      flag = 0;
      repeat (300) begin
         @(negedge clk);
         if (tx !== 1'b1 || fifo_count !== 3'd2) flag = 1;
      end
      total++; if (flag) begin $display("FAIL pause_hold: got activity want tx=1 count=2"); bad++; end
      total++; if (rx_word.size() != 1) begin $display("FAIL pause_frames: got %0d want 1", rx_word.size()); bad++; end
      pause = 1'b0;
      dcyc = cyc_n;
      wait_rx(3, 3 * (FRAME + 1) + 100);
      total++; if (rx_word.size() != 3) begin $display("FAIL pause_resume_frames: got %0d want 3", rx_word.size()); bad++; end
      else begin
         total++; if (rx_start[1] != dcyc + 1) begin $display("FAIL pause_resume_start: got %0d want %0d", rx_start[1], dcyc + 1); bad++; end
         total++; if (rx_start[2] - rx_start[1] != FRAME + 1) begin $display("FAIL pause_gap: got %0d want %0d", rx_start[2] - rx_start[1], FRAME + 1); bad++; end
         for (int i = 0; i < 3; i++) begin
            total++; if (rx_word[i] !== exp_q[i]) begin $display("FAIL pause_word[%0d]: got %h want %h", i, rx_word[i], exp_q[i]); bad++; end
         end
      end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int e0; int e; bit acc; int s; int t; bit flag;
      clear_obs();
      push_now(rand_word(), e0, acc);
      s = e0 + 1;
      for (int k = 0; k < 3; k++) push_now(rand_word(), e, acc);
      total++; if (fifo_count !== 3'd3) begin $display("FAIL rstmid_queued: got %0d want 3", fifo_count); bad++; end
      t = 0;
      while (cyc_n < s + 49 && t < FRAME) begin
         @(negedge clk); t++;
      end
      rst = 1'b1;
      @(negedge clk);
      total++; if (tx !== 1'b1) begin $display("FAIL rstmid_tx: got %b want 1", tx); bad++; end
      total++; if (tx_busy !== 1'b0) begin $display("FAIL rstmid_busy: got %b want 0", tx_busy); bad++; end
      total++; if (fifo_count !== 3'd0) begin $display("FAIL rstmid_count: got %0d want 0", fifo_count); bad++; end
      total++; if (frame_done !== 1'b0) begin $display("FAIL rstmid_done: got %b want 0", frame_done); bad++; end
      @(negedge clk);
      rst = 1'b0;
      flag = 0;
      repeat (2 * FRAME) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_busy !== 1'b0) flag = 1;
      end
      total++; if (flag) begin $display("FAIL rstmid_quiet: got line activity want idle"); bad++; end
      total++; if (rx_word.size() != 0 || done_q.size() != 0) begin
         $display("FAIL rstmid_frames: got %0d frames %0d dones want 0", rx_word.size(), done_q.size()); bad++; end
   endtask

   task automatic test_parity();
      int e; bit acc; logic [W-1:0] v;
      clear_obs();
      for (int k = 0; k < 3; k++) begin
         v = (k == 0) ? 37'h1F_FFFF_FFFF : (k == 1) ? 37'h10_0000_0001 : 37'h0;
         push_now(v, e, acc); exp_q.push_back(v);
      end
      wait_rx(3, 3 * (FRAME + 1) + 100);
      total++; if (rx_word.size() != 3) begin $display("FAIL parity_frames: got %0d want 3", rx_word.size()); bad++; end
      for (int i = 0; i < 3 && i < rx_word.size(); i++) begin
         total++; if (rx_word[i] !== exp_q[i]) begin $display("FAIL parity_word[%0d]: got %h want %h", i, rx_word[i], exp_q[i]); bad++; end
         total++; if (rx_par[i] !== model_par(exp_q[i])) begin $display("FAIL parity_bit[%0d]: got %b want %b", i, rx_par[i], model_par(exp_q[i])); bad++; end
         total++; if (rx_good[i] !== 1'b1) begin $display("FAIL parity_framing[%0d]: got %b want 1", i, rx_good[i]); bad++; end
      end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_random();
      int e; bit acc; int t; logic [W-1:0] d;
      clear_obs();
      for (int k = 0; k < 8; k++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         t = 0;
         while (nif.in_ready !== 1'b1 && t < 2 * FRAME) begin
            @(negedge clk); t++;
         end
         d = rand_word();
         push_now(d, e, acc);
         if (acc) exp_q.push_back(d);
      end
      total++; if (exp_q.size() != 8) begin $display("FAIL random_accepts: got %0d want 8", exp_q.size()); bad++; end
      wait_rx(exp_q.size(), exp_q.size() * (FRAME + 1) + 200);
      total++; if (rx_word.size() != exp_q.size()) begin $display("FAIL random_frames: got %0d want %0d", rx_word.size(), exp_q.size()); bad++; end
      for (int i = 0; i < exp_q.size() && i < rx_word.size(); i++) begin
         total++; if (rx_word[i] !== exp_q[i]) begin $display("FAIL random_word[%0d]: got %h want %h", i, rx_word[i], exp_q[i]); bad++; end
         total++; if (rx_par[i] !== model_par(exp_q[i])) begin $display("FAIL random_parity[%0d]: got %b want %b", i, rx_par[i], model_par(exp_q[i])); bad++; end
         total++; if (rx_good[i] !== 1'b1) begin $display("FAIL random_framing[%0d]: got %b want 1", i, rx_good[i]); bad++; end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_full_pop();
      test_pause();
      test_reset_mid();
      test_parity();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/sc_note_serializer.md
Name: sc_note_serializer

Overview:
- Transmit end of the note-data link. Accepts 37-bit note words from the chart/note source, buffers them in a small FIFO, and sends them as framed serial bits.
- The scoring block's deserializer rebuilds NDATA from this stream.
- Frame format: start bit, 37 data bits LSB first, even-parity bit, stop bit.
- Line idles high.

Parameters:
- WIDTH, 37, note word width. Must match the NDATA width.
- CLKS_PER_BIT, 16, clk cycles per serial bit. Minimum 2.
- FIFO_DEPTH, 4, entries in the input FIFO. Power of 2, minimum 2.

Ports:
- clk  input  1  100 MHz system clock.
- rst  input  1  synchronous reset, active-high.
- pause  input  1  game pause. Blocks the start of new frames only.
- in_data  input  WIDTH  note word to send.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  FIFO can accept a word. High when count < FIFO_DEPTH.
- tx  output  1  serial line.
- tx_busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse on the last cycle of STOP.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:

Single clock domain; reset is synchronous, active-high.

Reset values:
- tx=1, tx_busy=0, frame_done=0, fifo_count=0, in_ready=1.
- FSM goes to IDLE.
- FIFO pointers and all counters are cleared.

Reset mid-frame:
- Frame is aborted and FIFO contents are discarded.
- tx is high from the cycle after the reset edge.

Push:
- A word is accepted on a rising edge where in_valid && in_ready.
- in_ready depends only on the registered count. When the FIFO is full, no word is accepted that cycle even if a pop happens.
- Push and pop in the same cycle: count is unchanged, data is preserved, and FIFO order is kept.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If count>0 and !pause: pop the head into the shift register, compute even parity (XOR of all 37 bits), clear the bit and cycle counters, go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shreg[0].
  - Shift right after each CLKS_PER_BIT cycles.
  - After WIDTH bits, go to PARITY.
- PARITY:
  - tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - frame_done=1 on the final cycle.
  - Then go to IDLE.

Timing:
- tx is driven combinationally from the registered state and shift register, so it is glitch-free per state.
- Frame length is exactly (WIDTH+3)*CLKS_PER_BIT cycles, from the first START cycle to the last STOP cycle.
- Back-to-back frames have exactly one IDLE cycle (tx=1) between the last STOP cycle and the next START.
- Latency: a word accepted at edge N into an empty FIFO with the FSM idle gives count=1 after N, pop at edge N+1, and tx=0 from after edge N+1.

pause:
- Checked only in IDLE.
- A frame in progress always completes.
- Words keep being accepted while paused until the FIFO is full.

Counter widths:
- Cycle counter: clog2(CLKS_PER_BIT) bits, wraps at CLKS_PER_BIT-1.
- Bit counter: clog2(WIDTH) bits.
- No arithmetic overflow is possible.

Test Plan:
- Single word, CLKS_PER_BIT=4, in_data=37'h0_0000_0007:
  - tx falls 2 edges after accept.
  - 4 cycles low.
  - Data bits 1,1,1 followed by 34 zeros, 4 cycles each.
  - Parity=1.
  - Stop high.
  - frame_done pulses at cycle 160 of the frame.
  - tx_busy is high for exactly 160 cycles.
- Fill FIFO: push 5 words on consecutive cycles while FIFO_DEPTH=4 and the FSM is idle:
  - Words 1–4 are accepted and word 1 is popped, so the 5th is accepted.
  - in_ready drops when count=4.
  - All 5 frames emerge in order, each separated by exactly 1 idle cycle.
- Full FIFO during a frame, with a new in_valid on the same cycle as the IDLE pop:
  - The word is not accepted.
  - in_ready goes high the cycle after the pop.
- pause asserted mid-frame with 2 words queued:
  - The current frame finishes.
  - tx stays high and fifo_count stays at 2 while paused.
  - Deassert pause: the next START begins one edge later.
- Reset at cycle 50 of a frame with 3 words queued:
  - Next cycle: tx=1, tx_busy=0, fifo_count=0, no frame_done.
  - Nothing is transmitted afterward without new pushes.
- Parity sweep:
  - in_data = 37'h1F_FFFF_FFFF (37 ones) gives parity bit 1.
  - in_data = 37'h10_0000_0001 gives parity bit 0.
  - in_data = 0 gives parity bit 0 and an all-low data field.
